instr_mem_loader: RTL
=====================

Name: instr_mem_loader

Overview:
Copies a block of 32-bit instruction words from the disk (HD) read port into instruction memory through its write port. It is launched by the CPU when it executes the copy-to-instruction-memory instruction, which the boot program uses to load the OS image. It is the writer side of the instruction store; the fetch path is the reader. The CPU stalls on `busy` until `done` pulses.

Parameters:
ADDR_W, 16, width of HD and instruction-memory word addresses
DATA_W, 32, instruction word width
MEM_DEPTH, 512, number of instruction-memory words; bounds-check limit

Ports:
clock  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-high; clears all state
start  in  1  one-cycle launch request from CPU
src_addr  in  ADDR_W  first HD word address, sampled with start
dst_addr  in  ADDR_W  first instruction-memory address, sampled with start
word_count  in  ADDR_W  number of words to copy, sampled with start
hd_rd_en  out  1  HD read strobe
hd_addr  out  ADDR_W  HD read address
hd_data  in  DATA_W  HD read data, valid exactly 1 cycle after hd_rd_en
mem_we  out  1  instruction-memory write enable
mem_addr  out  ADDR_W  instruction-memory write address
mem_data  out  DATA_W  instruction-memory write data
busy  out  1  high while a copy is in progress; CPU stall
done  out  1  one-cycle pulse when a copy completes (including zero-length)
error  out  1  one-cycle pulse, in place of done, when a request is out of bounds

Behaviour:
- Reset: state IDLE; all outputs are 0; counters and captured addresses are 0. Reset asserted mid-copy aborts immediately, and no further mem_we occurs.
- All outputs are registered.
- States: IDLE, CHECK, STREAM, DRAIN, FINISH.
- IDLE: on start=1, capture src_addr, dst_addr and word_count, then go to CHECK. start is ignored in every other state.
- CHECK (1 cycle), busy=1:
  - If word_count==0: go to FINISH with done.
  - Else if dst+count > MEM_DEPTH (computed at ADDR_W+1 bits, no wrap): go to FINISH with error; no HD or memory access occurs.
  - Else go to STREAM.
- STREAM: hd_rd_en=1 each cycle with hd_addr = src, src+1, …, src+N-1 (one read per cycle).
  - Each returned word is registered and written the following cycle. mem_we=1, mem_addr=dst+i, mem_data=word i.
  - Read-issue to memory-write latency is 2 cycles. Throughput is 1 word/cycle.
  - After the last read is issued, go to DRAIN.
- DRAIN: no reads; the final 1–2 in-flight writes complete. When the write of word N-1 is done, go to FINISH.
- FINISH (1 cycle): pulse done or error; busy=0 from this cycle; return to IDLE.
- Timing for N≥1 (edge 0 samples start):
  - CHECK after edge 1.
  - Reads after edges 2..N+1.
  - Writes after edges 4..N+3.
  - done after edge N+4.
  - busy is high after edges 1..N+3.
- Zero-length timing: busy high for 1 cycle, done after edge 2.
- HD address arithmetic is modulo 2^ADDR_W; the src wrap from 0xFFFF to 0x0000 is legal.
- Exactly N writes per successful copy, in ascending address order, with no duplicate or skipped address.
- start coincident with reset: reset wins.

Decomposition:
- Shared package: state encoding (IDLE/CHECK/STREAM/DRAIN/FINISH), ADDR_W/DATA_W defaults, MEM_DEPTH constant shared with the instruction-memory block.
- One natural sub-module, `loader_addr_gen`: a loadable counter pair (read index, write index) with terminal-count flags. The FSM stays in the top.

Test Plan:
1. src=0, dst=0, count=310 (OS image), HD word k = 0xA000_0000+k → 310 writes, addr k holds 0xA000_0000+k; done after edge 314; busy high 313 cycles.
2. count=0 → no hd_rd_en, no mem_we; done after edge 2, busy for 1 cycle.
3. dst=500, count=13 with MEM_DEPTH=512 → error pulse after edge 2, zero writes, done never pulses; then dst=500, count=12 → 12 writes to 500..511, done.
4. src=0xFFFE, dst=10, count=4 → hd_addr sequence FFFE, FFFF, 0000, 0001; writes to 10..13.
5. Second start pulse during copy of count=8 → ignored; exactly 8 writes, one done.
6. Reset asserted after the 3rd write of a count=20 copy → outputs 0 within the same cycle, no further mem_we; a new start after release runs normally.

Source files
------------

// File: rtl/instr_mem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: default widths,
// the instruction-memory depth and the loader FSM state encoding.
package instr_mem_loader_pkg;

    localparam int IML_ADDR_W    = 16;
    localparam int IML_DATA_W    = 32;
    localparam int IML_MEM_DEPTH = 512;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE   = 3'd0;
    localparam state_t S_CHECK  = 3'd1;
    localparam state_t S_STREAM = 3'd2;
    localparam state_t S_DRAIN  = 3'd3;
    localparam state_t S_FINISH = 3'd4;

endpackage

// File: rtl/instr_mem_loader_addr_gen.sv
// Read/write index counter pair for the loader, cleared at launch, with flags
// that say when every read has been issued and every write has landed.
module loader_addr_gen
    import instr_mem_loader_pkg::*;
#(
    parameter int ADDR_W = IML_ADDR_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clear_i,
    input  logic              rd_inc_i,
    input  logic              wr_inc_i,
    input  logic [ADDR_W-1:0] count_i,
    output logic [ADDR_W-1:0] rd_idx_o,
    output logic [ADDR_W-1:0] wr_idx_o,
    output logic              rd_done_o,
    output logic              wr_done_o
);

    logic [ADDR_W-1:0] rd_idx_q, rd_idx_d;
    logic [ADDR_W-1:0] wr_idx_q, wr_idx_d;

    always_comb begin
        rd_idx_d = rd_idx_q;
        wr_idx_d = wr_idx_q;
        if (clear_i) begin
            rd_idx_d = '0;
            wr_idx_d = '0;
        end else begin
            if (rd_inc_i) rd_idx_d = rd_idx_q + 1'b1;
            if (wr_inc_i) wr_idx_d = wr_idx_q + 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_idx_q <= '0;
            wr_idx_q <= '0;
        end else begin
            rd_idx_q <= rd_idx_d;
            wr_idx_q <= wr_idx_d;
        end
    end

    // Terminal counts: index equals the requested length once all are done.
    assign rd_idx_o  = rd_idx_q;
    assign wr_idx_o  = wr_idx_q;
    assign rd_done_o = (rd_idx_q == count_i);
    assign wr_done_o = (wr_idx_q == count_i);

endmodule

// File: rtl/instr_mem_loader.sv
// Copies a block of instruction words from the HD read port into instruction
// memory, stalling the CPU via busy until done (or error) pulses.
module instr_mem_loader
    import instr_mem_loader_pkg::*;
#(
    parameter int ADDR_W    = IML_ADDR_W,
    parameter int DATA_W    = IML_DATA_W,
    parameter int MEM_DEPTH = IML_MEM_DEPTH
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [ADDR_W-1:0] word_count,
    output logic              hd_rd_en,
    output logic [ADDR_W-1:0] hd_addr,
    input  logic [DATA_W-1:0] hd_data,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam logic [ADDR_W:0] DEPTH_LIMIT = (ADDR_W+1)'(MEM_DEPTH);

    state_t            state_q, state_d;
    logic              launch_q;
    logic [ADDR_W-1:0] src_q, dst_q, count_q;
    logic              hd_rd_en_q;
    logic [ADDR_W-1:0] hd_addr_q;
    logic              rd_pend_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_data_q;
    logic              busy_q, done_q, error_q;

    logic              accept;
    logic              out_of_bounds;
    logic              error_d, done_d;
    logic              rd_inc;
    logic [ADDR_W-1:0] rd_idx, wr_idx;
    logic              rd_done, wr_done;
    logic [ADDR_W:0]   end_addr;

    // A launch is accepted only from a quiet IDLE; start is otherwise ignored.
    assign accept   = (state_q == S_IDLE) && !launch_q && start;
    assign end_addr = {1'b0, dst_q} + {1'b0, count_q};
    assign out_of_bounds = (end_addr > DEPTH_LIMIT);
    assign rd_inc   = (state_d == S_STREAM);

    loader_addr_gen #(
        .ADDR_W(ADDR_W)
    ) u_addr_gen (
        .clock     (clock),
        .reset     (reset),
        .clear_i   ((state_q == S_IDLE) && launch_q),
        .rd_inc_i  (rd_inc),
        .wr_inc_i  (rd_pend_q),
        .count_i   (count_q),
        .rd_idx_o  (rd_idx),
        .wr_idx_o  (wr_idx),
        .rd_done_o (rd_done),
        .wr_done_o (wr_done)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (launch_q) state_d = S_CHECK;
            S_CHECK: begin
                if ((count_q == '0) || out_of_bounds) state_d = S_FINISH;
                else                                  state_d = S_STREAM;
            end
            S_STREAM: if (rd_done) state_d = S_DRAIN;
            S_DRAIN:  if (wr_done) state_d = S_FINISH;
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    assign error_d = (state_q == S_CHECK) && (count_q != '0) && out_of_bounds;
    assign done_d  = (state_d == S_FINISH) && !error_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            launch_q <= 1'b0;
            src_q    <= '0;
            dst_q    <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            launch_q <= accept;
            if (accept) begin
                src_q   <= src_addr;
                dst_q   <= dst_addr;
                count_q <= word_count;
            end
        end
    end

    // Read issue -> data valid -> memory write: two registered stages.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hd_rd_en_q <= 1'b0;
            hd_addr_q  <= '0;
            rd_pend_q  <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            hd_rd_en_q <= rd_inc;
            if (rd_inc) hd_addr_q <= src_q + rd_idx;
            rd_pend_q  <= hd_rd_en_q;
            mem_we_q   <= rd_pend_q;
            if (rd_pend_q) begin
                mem_addr_q <= dst_q + wr_idx;
                mem_data_q <= hd_data;
            end
            busy_q  <= (state_d == S_CHECK) || (state_d == S_STREAM) ||
                       (state_d == S_DRAIN);
            done_q  <= done_d;
            error_q <= error_d;
        end
    end

    assign hd_rd_en = hd_rd_en_q;
    assign hd_addr  = hd_addr_q;
    assign mem_we   = mem_we_q;
    assign mem_addr = mem_addr_q;
    assign mem_data = mem_data_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign error    = error_q;

endmodule
